imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port, word-wide program/data memory among three requesters: instruction fetch (IF), load/store unit (LS) and the UART program loader (LD).
- Grants at most one access per cycle and returns read data one cycle later to the requester that issued the read.
- Holds the CPU off memory while a program download is running.
- Includes an anti-starvation counter so that back-to-back LS traffic cannot block fetch indefinitely.

Parameters:
- ADDR_W, 14, byte address width of all requester address ports
- DATA_W, 32, data word width
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch outranks LS; legal range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (one cycle after the grant)
- if_rdata  out  DATA_W  fetch read data
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  LS byte address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  LS granted this cycle (combinational)
- ls_rvalid  out  1  ls_rdata valid
- ls_rdata  out  DATA_W  load data
- ld_start  in  1  one-cycle pulse: begin download session
- ld_done  in  1  one-cycle pulse: end download session
- ld_we  in  1  loader write strobe
- ld_addr  in  ADDR_W  loader byte address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader write accepted this cycle
- ld_active  out  1  registered; 1 while in state LOAD
- cpu_hold  out  1  ld_active OR (if_req AND NOT if_gnt)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after mem_en with mem_we=0

Behaviour:
- FSM states:
  - RUN: CPU owns memory.
  - LOAD: loader owns memory.
- Reset (rst_n=0 at posedge):
  - state=RUN, starve_cnt=0, rd_tag=NONE.
  - All registered outputs 0: if_rvalid, ls_rvalid, ld_active.
- Address mapping: mem_addr = granted_addr[ADDR_W-1:2]; addr[1:0] ignored (no misalign check).
- Grant in RUN, combinational, exactly one or none:
  - If ls_req and not (if_req and starve_cnt>=STARVE_MAX): ls_gnt=1.
  - Else if if_req: if_gnt=1.
  - ld_gnt=0 in RUN; ld_we is ignored.
- Grant in LOAD:
  - ld_gnt=ld_we.
  - if_gnt=ls_gnt=0 regardless of requests.
- Memory drive:
  - mem_en = any grant.
  - mem_we = (ls_gnt & ls_we) | ld_gnt.
  - mem_wdata from the granted writer; 0 when idle.
- Read return:
  - rd_tag is registered: IF if if_gnt; LS if ls_gnt & ~ls_we; else NONE.
  - Next cycle: if_rvalid=(rd_tag==IF), ls_rvalid=(rd_tag==LS).
  - if_rdata and ls_rdata = mem_rdata when the matching rvalid is 1, else 0.
  - Latency is exactly 1 cycle. Stores and loader writes produce no rvalid.
- Starvation counter:
  - starve_cnt increments (saturating at 15) each RUN cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt or if_req=0.
  - Held at 0 in LOAD.
- Transitions:
  - RUN to LOAD when ld_start=1. The grant in that cycle still follows RUN rules. LOAD is effective from the next cycle; ld_active rises with it.
  - LOAD to RUN when ld_done=1. A ld_we in the same cycle is still granted. RUN is effective from the next cycle.
  - ld_start while in LOAD: ignored. ld_done while in RUN: ignored.
  - ld_start and ld_done together in RUN: go to LOAD.
  - ld_start and ld_done together in LOAD: go to RUN.
- In-flight read at the RUN to LOAD boundary: the read granted in the ld_start cycle still returns its rvalid in the first LOAD cycle.
- Reset mid-operation: a pending rd_tag is dropped and no rvalid is issued after reset.

Test Plan:
- Reset: rst_n=0 with all reqs high → all gnt/rvalid/ld_active 0, mem_en=0. First cycle after release with if_req=1, if_addr=0x0010 → if_gnt=1, mem_addr=0x004; next cycle if_rvalid=1 and if_rdata=mem_rdata.
- Conflict: if_req=1 and ls_req=1 (load, ls_addr=0x0100) → ls_gnt=1, if_gnt=0, cpu_hold=1; next cycle ls_rvalid=1, if_rvalid=0.
- Starvation: if_req and ls_req held high → ls granted 4 cycles, 5th cycle if_gnt=1 and ls_gnt=0, counter clears, ls granted again on the 6th.
- Store: ls_we=1, ls_addr=0x0203, ls_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x080, mem_wdata=0xDEADBEEF; no ls_rvalid the next cycle.
- Download session:
  - ld_start pulse while an if read is granted → if_rvalid still asserts next cycle and ld_active=1.
  - During LOAD, if_req/ls_req are never granted and cpu_hold=1.
  - ld_we writes (addr 0x0000 and 0x0004, data 0x11, 0x22) → mem_addr 0x000 then 0x001.
  - ld_done with ld_we=1 → that write is granted; RUN from the next cycle.
- Reset during LOAD with a pending read tag → RUN, ld_active=0, no rvalid on the following cycle.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port memory arbiter for fetch, load/store and UART loader.
// Rev 1.0
`default_nettype none

module imem_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   input  logic                ld_start,
   input  logic                ld_done,
   input  logic                ld_we,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_wdata,
   output logic                ld_gnt,
   output logic                ld_active,
   output logic                cpu_hold,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-3:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_LS   = 2'd2
   } tag_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state, state_nxt;
   tag_t       rd_tag, rd_tag_nxt;
   logic [3:0] starve_cnt, starve_nxt;

   // Byte-offset bits are deliberately dropped on the word-wide memory.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0], ld_addr[1:0]};

   always_comb begin
      if_gnt     = 1'b0;
      ls_gnt     = 1'b0;
      ld_gnt     = 1'b0;
      state_nxt  = state;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      rd_tag_nxt = TAG_NONE;
      starve_nxt = '0;

      if (state == RUN) begin
         ls_gnt = ls_req & ~(if_req & (starve_cnt >= STARVE_LIM));
         if_gnt = if_req & ~ls_gnt;
         if (ld_start) state_nxt = LOAD;
      end else begin
         ld_gnt = ld_we;
         if (ld_done) state_nxt = RUN;
      end

      // No grant may reach the memory while reset is applied.
      if (!rst_n) begin
         if_gnt = 1'b0;
         ls_gnt = 1'b0;
         ld_gnt = 1'b0;
      end

      if (ld_gnt) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = ld_addr[ADDR_W-1:2];
         mem_wdata = ld_wdata;
      end else if (ls_gnt) begin
         mem_en   = 1'b1;
         mem_we   = ls_we;
         mem_addr = ls_addr[ADDR_W-1:2];
         if (ls_we) mem_wdata = ls_wdata;
         else       rd_tag_nxt = TAG_LS;
      end else if (if_gnt) begin
         mem_en     = 1'b1;
         mem_addr   = if_addr[ADDR_W-1:2];
         rd_tag_nxt = TAG_IF;
      end

      if ((state == RUN) && if_req && !if_gnt)
         starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         rd_tag     <= TAG_NONE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         rd_tag     <= rd_tag_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   assign ld_active = (state == LOAD);
   assign if_rvalid = (rd_tag == TAG_IF);
   assign ls_rvalid = (rd_tag == TAG_LS);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
   assign cpu_hold  = ld_active | (if_req & ~if_gnt);

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter with a synchronous memory model.
`default_nettype none

module tb_imem_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic              ld_start = 1'b0, ld_done = 1'b0, ld_we = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0, ls_addr = '0, ld_addr = '0;
   logic [DATA_W-1:0] ls_wdata = '0, ld_wdata = '0;
   logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, ld_gnt, ld_active, cpu_hold;
   logic              mem_en, mem_we;
   logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [ADDR_W-3:0] mem_addr;

   imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .ld_start(ld_start), .ld_done(ld_done), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_active(ld_active), .cpu_hold(cpu_hold),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory seen by the arbiter.
   logic [DATA_W-1:0] mem_array [0:4095];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_array[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_array[mem_addr];
      end
   end

   function automatic logic [31:0] pattern(int w);
      return 32'hC0DE_0000 | 32'(w);
   endfunction

   logic [31:0] shadow [int];
   function automatic logic [31:0] exp_word(int w);
      return shadow.exists(w) ? shadow[w] : pattern(w);
   endfunction

   typedef struct {
      bit          is_if;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t exp_q [$];
   int      n_checks = 0;
   int      n_errors = 0;
   bit      mon_en = 1'b0;

   // Scoreboard: every granted read must come back exactly one cycle later.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            rd_exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (e.is_if) begin
               if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || if_rdata !== e.data || ls_rdata !== '0) begin
                  n_errors++;
                  $display("FAIL if_read: got if_rvalid=%b ls_rvalid=%b if_rdata=%h ls_rdata=%h expected 1 0 %h 0",
                           if_rvalid, ls_rvalid, if_rdata, ls_rdata, e.data);
               end
            end else begin
               if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0 || ls_rdata !== e.data || if_rdata !== '0) begin
                  n_errors++;
                  $display("FAIL ls_read: got ls_rvalid=%b if_rvalid=%b ls_rdata=%h if_rdata=%h expected 1 0 %h 0",
                           ls_rvalid, if_rvalid, ls_rdata, if_rdata, e.data);
               end
            end
         end else if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_rdata !== '0 || ls_rdata !== '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL spurious_rvalid: got if_rvalid=%b ls_rvalid=%b if_rdata=%h ls_rdata=%h expected all 0",
                     if_rvalid, ls_rvalid, if_rdata, ls_rdata);
         end
      end
   end

   task automatic idle_inputs();
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      ld_start = 1'b0; ld_done = 1'b0; ld_we = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; ld_we = 1'b1;
      #1;
      n_checks++;
      if ({if_gnt, ls_gnt, ld_gnt, mem_en} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_grants: got gnt(if,ls,ld),mem_en=%b expected 0000", {if_gnt, ls_gnt, ld_gnt, mem_en});
      end
      n_checks++;
      if ({if_rvalid, ls_rvalid, ld_active} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_regs: got if_rvalid,ls_rvalid,ld_active=%b expected 000", {if_rvalid, ls_rvalid, ld_active});
      end
      mon_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; idle_inputs();
      if_req = 1'b1; if_addr = 14'h0010;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h004) begin
         n_errors++;
         $display("FAIL first_fetch: got if_gnt=%b ls_gnt=%b mem_en=%b mem_we=%b mem_addr=%h expected 1 0 1 0 004",
                  if_gnt, ls_gnt, mem_en, mem_we, mem_addr);
      end
      exp_q.push_back('{is_if: 1'b1, data: exp_word(4)});
   endtask

   task automatic test_conflict();
      @(negedge clk);
      if_req = 1'b1; if_addr = 14'h0020;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 14'h0100;
      #1;
      n_checks++;
      if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || cpu_hold !== 1'b1 || mem_addr !== 12'h040) begin
         n_errors++;
         $display("FAIL conflict: got ls_gnt=%b if_gnt=%b cpu_hold=%b mem_addr=%h expected 1 0 1 040",
                  ls_gnt, if_gnt, cpu_hold, mem_addr);
      end
      exp_q.push_back('{is_if: 1'b0, data: exp_word(12'h040)});
   endtask

   task automatic test_starvation();
      @(negedge clk);
      idle_inputs();
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 14'(14'h0300 + 4 * k);
         ls_req = 1'b1; ls_we = 1'b0; ls_addr = 14'(14'h0100 + 4 * k);
         #1;
         n_checks++;
         if (if_gnt !== (k == 5) || ls_gnt !== (k != 5)) begin
            n_errors++;
            $display("FAIL starve_cycle%0d: got if_gnt=%b ls_gnt=%b expected %b %b",
                     k, if_gnt, ls_gnt, (k == 5), (k != 5));
         end
         if (k == 5) exp_q.push_back('{is_if: 1'b1, data: exp_word(int'(if_addr >> 2))});
         else        exp_q.push_back('{is_if: 1'b0, data: exp_word(int'(ls_addr >> 2))});
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      idle_inputs();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 14'h0203; ls_wdata = 32'hDEADBEEF;
      ld_we = 1'b1; ld_addr = 14'h0008; ld_wdata = 32'h55;
      #1;
      n_checks++;
      if (ls_gnt !== 1'b1 || ld_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 12'h080 || mem_wdata !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL store: got ls_gnt=%b ld_gnt=%b mem_we=%b mem_addr=%h mem_wdata=%h expected 1 0 1 080 deadbeef",
                  ls_gnt, ld_gnt, mem_we, mem_addr, mem_wdata);
      end
      shadow[12'h080] = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (ls_rvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL store_no_rvalid: got ls_rvalid=%b expected 0", ls_rvalid);
      end
      ld_we = 1'b0; ls_we = 1'b0; ls_addr = 14'h0200;
      #1;
      n_checks++;
      if (ls_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h080) begin
         n_errors++;
         $display("FAIL store_readback_gnt: got ls_gnt=%b mem_we=%b mem_addr=%h expected 1 0 080", ls_gnt, mem_we, mem_addr);
      end
      exp_q.push_back('{is_if: 1'b0, data: exp_word(12'h080)});
   endtask

   task automatic test_download();
      @(negedge clk);
      idle_inputs();
      if_req = 1'b1; if_addr = 14'h0040; ld_start = 1'b1;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1 || ld_active !== 1'b0) begin
         n_errors++;
         $display("FAIL ld_start_fetch: got if_gnt=%b ld_active=%b expected 1 0", if_gnt, ld_active);
      end
      exp_q.push_back('{is_if: 1'b1, data: exp_word(12'h010)});
      @(negedge clk);
      ld_start = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 14'h0100;
      #1;
      n_checks++;
      if (ld_active !== 1'b1 || if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_en !== 1'b0 || cpu_hold !== 1'b1) begin
         n_errors++;
         $display("FAIL load_blocks_cpu: got ld_active=%b if_gnt=%b ls_gnt=%b mem_en=%b cpu_hold=%b expected 1 0 0 0 1",
                  ld_active, if_gnt, ls_gnt, mem_en, cpu_hold);
      end
      @(negedge clk);
      ld_start = 1'b0; ld_we = 1'b1; ld_addr = 14'h0000; ld_wdata = 32'h11;
      #1;
      n_checks++;
      if (ld_gnt !== 1'b1 || if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 12'h000 || mem_wdata !== 32'h11) begin
         n_errors++;
         $display("FAIL ld_write0: got ld_gnt=%b if_gnt=%b ls_gnt=%b mem_we=%b mem_addr=%h mem_wdata=%h expected 1 0 0 1 000 00000011",
                  ld_gnt, if_gnt, ls_gnt, mem_we, mem_addr, mem_wdata);
      end
      shadow[0] = 32'h11;
      @(negedge clk);
      ld_addr = 14'h0004; ld_wdata = 32'h22; ld_done = 1'b1;
      #1;
      n_checks++;
      if (ld_gnt !== 1'b1 || ld_active !== 1'b1 || mem_addr !== 12'h001 || mem_wdata !== 32'h22 || cpu_hold !== 1'b1) begin
         n_errors++;
         $display("FAIL ld_done_write: got ld_gnt=%b ld_active=%b mem_addr=%h mem_wdata=%h cpu_hold=%b expected 1 1 001 00000022 1",
                  ld_gnt, ld_active, mem_addr, mem_wdata, cpu_hold);
      end
      shadow[1] = 32'h22;
      @(negedge clk);
      idle_inputs();
      if_req = 1'b1; if_addr = 14'h0004; ld_done = 1'b1;
      #1;
      n_checks++;
      if (ld_active !== 1'b0 || if_gnt !== 1'b1 || mem_addr !== 12'h001 || cpu_hold !== 1'b0) begin
         n_errors++;
         $display("FAIL back_to_run: got ld_active=%b if_gnt=%b mem_addr=%h cpu_hold=%b expected 0 1 001 0",
                  ld_active, if_gnt, mem_addr, cpu_hold);
      end
      exp_q.push_back('{is_if: 1'b1, data: exp_word(1)});
   endtask

   task automatic test_reset_in_load();
      @(negedge clk);
      idle_inputs();
      if_req = 1'b1; if_addr = 14'h0008; ld_start = 1'b1; ld_done = 1'b1;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1) begin
         n_errors++;
         $display("FAIL start_done_fetch: got if_gnt=%b expected 1", if_gnt);
      end
      exp_q.push_back('{is_if: 1'b1, data: exp_word(2)});
      @(negedge clk);
      ld_start = 1'b0; ld_done = 1'b0; rst_n = 1'b0;
      #1;
      n_checks++;
      if (ld_active !== 1'b1 || if_gnt !== 1'b0) begin
         n_errors++;
         $display("FAIL start_done_load: got ld_active=%b if_gnt=%b expected 1 0", ld_active, if_gnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (ld_active !== 1'b0 || if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_in_load: got ld_active=%b if_rvalid=%b ls_rvalid=%b expected 0 0 0",
                  ld_active, if_rvalid, ls_rvalid);
      end
      #1;
      n_checks++;
      if (if_gnt !== 1'b1) begin
         n_errors++;
         $display("FAIL run_after_reset: got if_gnt=%b expected 1", if_gnt);
      end
      exp_q.push_back('{is_if: 1'b1, data: exp_word(2)});
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem_array[i] = pattern(i);
      test_reset();
      test_conflict();
      test_starvation();
      test_store();
      test_download();
      test_reset_in_load();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

`default_nettype wire
